motor_mixer: RTL

MOTOR_MIXER -- requirements
Module: motor_mixer

---
 rtl/motor_mixer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/motor_mixer.sv
// Quad-X motor mixer: latches throttle and body rates, mixes one motor per
// cycle into shadows, then updates all four outputs together with a valid pulse.
// Optional build macro: MOTOR_ARM_INTERLOCK_EN (armed=0 holds motors at 0, FSM in IDLE).
module motor_mixer #(
  parameter int N_RATE     = 36,
  parameter int N_MOTOR    = 16,
  parameter int RATE_SHIFT = 20,
  parameter int MOTOR_MAX  = 2000
) (
  input  logic                      sys_clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [N_MOTOR-1:0]        throttle,
  input  logic signed [N_RATE-1:0]  yaw_rate,
  input  logic signed [N_RATE-1:0]  roll_rate,
  input  logic signed [N_RATE-1:0]  pitch_rate,
  input  logic                      armed,
  output logic [N_MOTOR-1:0]        motor_0,
  output logic [N_MOTOR-1:0]        motor_1,
  output logic [N_MOTOR-1:0]        motor_2,
  output logic [N_MOTOR-1:0]        motor_3,
  output logic                      busy,
  output logic                      valid
);

  localparam int SUM_W = N_RATE + 2;
  localparam int MIX_W = ((SUM_W > N_MOTOR + 1) ? SUM_W : N_MOTOR + 1) + 1;
  localparam logic signed [MIX_W-1:0] MAX_S = MIX_W'(MOTOR_MAX);
  localparam logic [N_MOTOR-1:0]      MAX_M = N_MOTOR'(MOTOR_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC0 = 3'd1,
    CALC1 = 3'd2,
    CALC2 = 3'd3,
    CALC3 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_arm_ok;
  logic   w_accept;

  logic [N_MOTOR-1:0]       r_thr;
  logic signed [N_RATE-1:0] r_yaw;
  logic signed [N_RATE-1:0] r_roll;
  logic signed [N_RATE-1:0] r_pitch;

  logic [N_MOTOR-1:0] r_sh0;
  logic [N_MOTOR-1:0] r_sh1;
  logic [N_MOTOR-1:0] r_sh2;

  logic                     w_neg_p;
  logic                     w_neg_r;
  logic                     w_neg_y;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_shift;
  logic signed [MIX_W-1:0]  w_mix;
  logic [N_MOTOR-1:0]       w_mot;

`ifdef MOTOR_ARM_INTERLOCK_EN
  assign w_arm_ok = armed;
`else
  logic w_unused_armed;
  assign w_unused_armed = armed;
  assign w_arm_ok       = 1'b1;
`endif

  assign w_accept = (r_state == IDLE) && start && w_arm_ok;

  function automatic logic signed [SUM_W-1:0] rate_term(
    input logic signed [N_RATE-1:0] v,
    input logic                     neg
  );
    logic signed [SUM_W-1:0] ext;
    ext = {{2{v[N_RATE-1]}}, v};
    return neg ? -ext : ext;
  endfunction

  function automatic logic [N_MOTOR-1:0] sat_motor(input logic signed [MIX_W-1:0] v);
    if (v[MIX_W-1])
      return '0;
    else if (v > MAX_S)
      return MAX_M;
    else
      return v[N_MOTOR-1:0];
  endfunction

  // State register
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CALC0;
      CALC0:   w_state_nxt = CALC1;
      CALC1:   w_state_nxt = CALC2;
      CALC2:   w_state_nxt = CALC3;
      CALC3:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (!w_arm_ok)
      w_state_nxt = IDLE;
  end

  // Output decode
  always_comb begin
    busy  = (r_state != IDLE);
    valid = (r_state == DONE);
  end

  // Operand capture: frozen for the whole mix
  always_ff @(posedge sys_clk) begin
    if (w_accept) begin
      r_thr   <= throttle;
      r_yaw   <= yaw_rate;
      r_roll  <= roll_rate;
      r_pitch <= pitch_rate;
    end
  end

  // Per-motor sign pattern: m0=+p+r-y, m1=+p-r+y, m2=-p-r-y, m3=-p+r+y
  always_comb begin
    w_neg_p = 1'b0;
    w_neg_r = 1'b0;
    w_neg_y = 1'b0;
    case (r_state)
      CALC0:   w_neg_y = 1'b1;
      CALC1:   w_neg_r = 1'b1;
      CALC2:   begin w_neg_p = 1'b1; w_neg_r = 1'b1; w_neg_y = 1'b1; end
      CALC3:   w_neg_p = 1'b1;
      default: ;
    endcase
  end

  assign w_sum   = rate_term(r_pitch, w_neg_p) + rate_term(r_roll, w_neg_r)
                 + rate_term(r_yaw, w_neg_y);
  assign w_shift = w_sum >>> RATE_SHIFT;
  assign w_mix   = {{(MIX_W-SUM_W){w_shift[SUM_W-1]}}, w_shift}
                 + {{(MIX_W-N_MOTOR){1'b0}}, r_thr};
  assign w_mot   = sat_motor(w_mix);

  // Shadows fill in CALC0..2; motor 3 is written straight into its output
  // register at the end of CALC3 so all four outputs appear together in DONE.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      motor_0 <= '0;
      motor_1 <= '0;
      motor_2 <= '0;
      motor_3 <= '0;
    end else if (!w_arm_ok) begin
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      motor_0 <= '0;
      motor_1 <= '0;
      motor_2 <= '0;
      motor_3 <= '0;
    end else begin
      case (r_state)
        CALC0: r_sh0 <= w_mot;
        CALC1: r_sh1 <= w_mot;
        CALC2: r_sh2 <= w_mot;
        CALC3: begin
          motor_0 <= r_sh0;
          motor_1 <= r_sh1;
          motor_2 <= r_sh2;
          motor_3 <= w_mot;
        end
        default: ;
      endcase
    end
  end

endmodule
